// File: rtl/policy_table_loader.sv
// Burst loader streaming DEPTH words into one of N_TABLES policy tables.
// Gated per initiator by load_ctrl, with abort, idle timeout and error codes.
module policy_table_loader #(
  parameter int N_PERIPH = 8,
  parameter int ID_W     = 3,
  parameter int DATA_W   = 32,
  parameter int N_TABLES = 3,
  parameter int SEL_W    = 2,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [SEL_W-1:0]    tbl_sel_i,
  input  logic [ID_W-1:0]     id_i,
  input  logic [N_PERIPH-1:0] load_ctrl_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                abort_i,
  output logic [N_TABLES-1:0] tbl_wr_o,
  output logic [ADDR_W-1:0]   tbl_addr_o,
  output logic [DATA_W-1:0]   tbl_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);

  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [1:0] ERR_SEL   = 2'd1;
  localparam logic [1:0] ERR_ABORT = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_TABLES-1:0] wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic ctrl_bit;
  logic beat;
  logic sel_ok;
  logic last;
  logic idle_exp;

  // Pick the initiator's enable bit; ids past the vector read as disabled
  always_comb begin
    ctrl_bit = 1'b0;
    for (int i = 0; i < N_PERIPH; i++) begin
      if (id_i == ID_W'(i)) begin
        ctrl_bit = load_ctrl_i[i];
      end
    end
  end

  assign ready_o  = (state_q == LOAD) & ctrl_bit;
  assign beat     = valid_i & ready_o;
  assign sel_ok   = int'(tbl_sel_i) < N_TABLES;
  assign last     = count_q == ADDR_W'(DEPTH - 1);
  assign idle_exp = (TIMEOUT != 0) && (timer_q == TW'(TMAX));

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    count_d = count_q;
    timer_d = timer_q;
    wr_d    = '0;
    addr_d  = '0;
    data_d  = '0;
    err_d   = 1'b0;
    code_d  = 2'd0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (sel_ok) begin
            sel_d   = tbl_sel_i;
            count_d = '0;
            timer_d = '0;
            state_d = LOAD;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_SEL;
          end
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
        end else if (beat) begin
          wr_d    = N_TABLES'(1) << sel_q;
          addr_d  = count_q;
          data_d  = data_i;
          timer_d = '0;
          if (last) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + ADDR_W'(1);
          end
        end else if (idle_exp) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TMO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      count_q <= '0;
      timer_q <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      timer_q <= timer_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign tbl_wr_o   = wr_q;
  assign tbl_addr_o = addr_q;
  assign tbl_data_o = data_q;
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_policy_table_loader.sv
// Bench for policy_table_loader: vector table, corner sequences,
// and random traffic against a burst-level reference model.
module tb_policy_table_loader;

  logic        clk = 1'b0;
  logic        rst_r;
  logic        start_r;
  logic [1:0]  sel_r;
  logic [2:0]  id_r;
  logic [7:0]  ctrl_r;
  logic [31:0] data_r;
  logic        valid_r;
  logic        abort_r;

  logic        ready_o;
  logic [2:0]  tbl_wr_o;
  logic [2:0]  tbl_addr_o;
  logic [31:0] tbl_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  always #5 clk = ~clk;

  policy_table_loader dut (
    .clk_i      (clk),
    .rst_i      (rst_r),
    .start_i    (start_r),
    .tbl_sel_i  (sel_r),
    .id_i       (id_r),
    .load_ctrl_i(ctrl_r),
    .data_i     (data_r),
    .valid_i    (valid_r),
    .ready_o    (ready_o),
    .abort_i    (abort_r),
    .tbl_wr_o   (tbl_wr_o),
    .tbl_addr_o (tbl_addr_o),
    .tbl_data_o (tbl_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: burst phase 0=closed 1=open 2=finishing
  int          m_phase = 0;
  int          m_sel   = 0;
  int          m_n     = 0;
  int          m_idle  = 0;
  logic [2:0]  x_wr, x_addr;
  logic [31:0] x_data;
  logic        x_busy, x_done, x_err;
  logic [1:0]  x_code;

  function automatic logic m_ready();
    return (m_phase == 1) && ctrl_r[id_r];
  endfunction

  task automatic model_step();
    logic r;
    r = m_ready();
    x_wr = 0; x_addr = 0; x_data = 0; x_err = 0; x_code = 0;
    if (rst_r) begin
      m_phase = 0; m_n = 0; m_idle = 0; m_sel = 0;
    end else if (m_phase == 0) begin
      if (start_r) begin
        if (sel_r < 3) begin
          m_sel = sel_r; m_n = 0; m_idle = 0; m_phase = 1;
        end else begin
          x_err = 1; x_code = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (abort_r) begin
        m_phase = 0; x_err = 1; x_code = 2;
      end else if (valid_r && r) begin
        x_wr   = 3'(1 << m_sel);
        x_addr = 3'(m_n);
        x_data = data_r;
        m_idle = 0;
        m_n++;
        if (m_n == 8) begin
          m_n = 0; m_phase = 2;
        end
      end else if (m_idle == 15) begin
        m_phase = 0; x_err = 1; x_code = 3;
      end else begin
        m_idle++;
      end
    end else begin
      m_phase = 0;
    end
    x_busy = m_phase != 0;
    x_done = m_phase == 2;
  endtask

  task automatic tick(input logic r, input logic s, input logic [1:0] sl,
                      input logic [2:0] i, input logic [7:0] c,
                      input logic [31:0] d, input logic v, input logic a);
    rst_r = r; start_r = s; sel_r = sl; id_r = i;
    ctrl_r = c; data_r = d; valid_r = v; abort_r = a;
    @(negedge clk);
    if (!r) chk("m_ready", ready_o, m_ready());
    model_step();
    @(posedge clk);
    #1;
    chk("m_wr", tbl_wr_o, x_wr);
    chk("m_addr", tbl_addr_o, x_addr);
    chk("m_data", tbl_data_o, x_data);
    chk("m_busy", busy_o, x_busy);
    chk("m_done", done_o, x_done);
    chk("m_err", err_o, x_err);
    chk("m_code", err_code_o, x_code);
  endtask

  task automatic beat(input logic [31:0] d);
    tick(0, 0, 0, 3'd2, 8'h04, d, 1, 0);
  endtask

  task automatic idle();
    tick(0, 0, 0, 3'd2, 8'h04, 0, 0, 0);
  endtask

  task automatic open(input logic [1:0] sl);
    tick(0, 1, sl, 3'd2, 8'h04, 0, 0, 0);
  endtask

  typedef struct {
    logic        rst, start;
    logic [1:0]  sel;
    logic [2:0]  id;
    logic [7:0]  ctrl;
    logic [31:0] data;
    logic        valid, abort;
    logic        e_ready;
    logic [2:0]  e_wr, e_addr;
    logic [31:0] e_data;
    logic        e_busy, e_done, e_err;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vecs[$];

  task automatic apply_vec(input int k, input vec_t v);
    rst_r = v.rst; start_r = v.start; sel_r = v.sel; id_r = v.id;
    ctrl_r = v.ctrl; data_r = v.data; valid_r = v.valid; abort_r = v.abort;
    @(negedge clk);
    if (!v.rst) chk($sformatf("v%0d_ready", k), ready_o, v.e_ready);
    model_step();
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_wr", k), tbl_wr_o, v.e_wr);
    chk($sformatf("v%0d_addr", k), tbl_addr_o, v.e_addr);
    chk($sformatf("v%0d_data", k), tbl_data_o, v.e_data);
    chk($sformatf("v%0d_busy", k), busy_o, v.e_busy);
    chk($sformatf("v%0d_done", k), done_o, v.e_done);
    chk($sformatf("v%0d_err", k), err_o, v.e_err);
    chk($sformatf("v%0d_code", k), err_code_o, v.e_code);
  endtask

  initial begin
    vec_t v;
    logic [7:0] c;
    logic [2:0] idr;
    int vp;

    // reset, full burst to table 1, ignored start in DONE, bad select
    vecs.push_back('{1,0,0,0,8'h00,0,0,0, 0,0,0,0,0,0,0,0});
    vecs.push_back('{1,0,0,0,8'h00,0,0,0, 0,0,0,0,0,0,0,0});
    vecs.push_back('{0,1,1,2,8'h04,0,0,0, 0,0,0,0,1,0,0,0});
    for (int i = 0; i < 8; i++) begin
      v = '{0,0,0,2,8'h04,32'hA0 + i,1,0,
            1,3'b010,3'(i),32'hA0 + i,1,(i == 7),0,0};
      vecs.push_back(v);
    end
    vecs.push_back('{0,1,0,2,8'h04,0,0,0, 0,0,0,0,0,0,0,0});
    vecs.push_back('{0,1,3,2,8'h04,0,0,0, 0,0,0,0,0,0,1,1});
    vecs.push_back('{0,0,0,2,8'h04,0,0,0, 0,0,0,0,0,0,0,0});
    foreach (vecs[k]) apply_vec(k, vecs[k]);

    tick(1, 0, 0, 0, 0, 0, 0, 0);

    // stall on load_ctrl drop after three words
    open(0);
    for (int i = 0; i < 3; i++) beat(32'hB0 + i);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 3'd2, 8'h00, 32'hEE, 1, 0);
      chk("stall_wr", tbl_wr_o, 0);
    end
    beat(32'hB3);
    chk("stall_resume_addr", tbl_addr_o, 3);
    for (int i = 4; i < 8; i++) beat(32'hB0 + i);
    chk("stall_done", done_o, 1);
    idle();

    // timeout after two words
    open(2);
    beat(32'hC0);
    beat(32'hC1);
    for (int i = 0; i < 16; i++) idle();
    chk("tmo_err", err_o, 1);
    chk("tmo_code", err_code_o, 3);
    chk("tmo_busy", busy_o, 0);
    idle();

    // abort coincident with the sixth beat
    open(1);
    for (int i = 0; i < 5; i++) beat(32'hD0 + i);
    tick(0, 0, 0, 3'd2, 8'h04, 32'hD5, 1, 1);
    chk("abort_wr", tbl_wr_o, 0);
    chk("abort_err", err_o, 1);
    chk("abort_code", err_code_o, 2);
    open(1);
    beat(32'hD9);
    chk("abort_new_addr", tbl_addr_o, 0);
    chk("abort_new_wr", tbl_wr_o, 3'b010);
    tick(0, 0, 0, 3'd2, 8'h04, 0, 0, 1);

    // reset during the fifth beat
    open(0);
    for (int i = 0; i < 4; i++) beat(32'hE0 + i);
    tick(1, 0, 0, 3'd2, 8'h04, 32'hE4, 1, 0);
    chk("rst_wr", tbl_wr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_done", done_o, 0);
    open(0);
    beat(32'hE9);
    chk("rst_new_addr", tbl_addr_o, 0);
    chk("rst_new_wr", tbl_wr_o, 3'b001);

    // random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vp = ((cyc / 250) % 3 == 2) ? 10 : 80;
      idr = ($urandom_range(0, 9) < 8) ? 3'd2 : 3'($urandom_range(0, 7));
      c = 8'($urandom);
      if ($urandom_range(0, 9) < 7) c[idr] = 1'b1;
      tick(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 4) == 0),
           2'($urandom_range(0, 3)),
           idr, c, $urandom,
           ($urandom_range(0, 99) < vp),
           ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
